// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   PC_W / INS_W   address and instruction widths
//   NOP_INSTR      ADDI x0,x0,0 presented to decode when no entry is valid
//   fetch_state_t  fetch FSM states
//   fetch_entry_t  one prefetch FIFO entry {pc, instr}
package fetch_pkg;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;

  localparam logic [INS_W-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [PC_W-1:0]  ALIGN_MASK = ~PC_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] p);
    return p + PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bus.
//   imem_req/imem_addr   request, address held stable until granted
//   imem_gnt             request accepted this cycle
//   imem_rvalid/rdata    one response per granted request, >=1 cycle after gnt
// master = fetch unit side, slave = instruction memory side.
interface fetch_if;
  import fetch_pkg::*;

  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [INS_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous prefetch FIFO of fetch_entry_t.
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        discard all entries (wins over push/pop)
//   push, wdata  write an entry
//   pop          remove the head entry
//   head         entry at the head (valid when !empty)
//   count        number of stored entries
//   full, empty  status flags
// DEPTH must be a power of two so the pointers wrap by overflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observed through
  // count/empty, which are reset, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage feeding the IF/ID register.
//   clk, reset         clock, asynchronous active-low reset
//   imem               instruction-memory bus (fetch_if.master)
//   fd_valid/fd_ready  handshake toward IF/ID
//   fd_instr/fd_pc     head instruction and its PC (NOP / 0 when invalid)
//   redirect           flush the prefetch FIFO and restart at redirect_pc
//   redirect_pc        new fetch target, low two bits forced to zero
// At most one request is outstanding; a new request is issued only while the
// FIFO plus the in-flight response still fit in DEPTH entries.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  fetch_if.master          imem,
  output logic             fd_valid,
  input  logic             fd_ready,
  output logic [INS_W-1:0] fd_instr,
  output logic [PC_W-1:0]  fd_pc,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [PC_W-1:0] pc_of_req;
  logic            outstanding, outstanding_nxt;

  logic            push, pop;
  fetch_entry_t    head, push_data;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            issue_ok, issue_ok_after_push;

  assign issue_ok            = (fifo_count + CW'(outstanding)) < DEPTH_C;
  assign issue_ok_after_push = (fifo_count + CW'(1)) < DEPTH_C;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    outstanding_nxt = outstanding;
    push            = 1'b0;

    if (redirect) begin
      pc_nxt = redirect_pc & ALIGN_MASK;
      case (state)
        IDLE:  state_nxt = REQ;
        REQ: begin
          if (imem.imem_gnt) begin
            state_nxt       = FLUSH;
            outstanding_nxt = 1'b1;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            state_nxt       = REQ;
            outstanding_nxt = 1'b0;
          end else begin
            state_nxt = FLUSH;
          end
        end
        FLUSH: begin
          // A stale response landing with a second redirect is still consumed,
          // otherwise FLUSH would wait for a response that never comes.
          if (imem.imem_rvalid) begin
            state_nxt       = REQ;
            outstanding_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (issue_ok) state_nxt = REQ;
        end
        REQ: begin
          if (imem.imem_gnt) begin
            state_nxt       = WAIT;
            pc_nxt          = pc_plus4(pc);
            outstanding_nxt = 1'b1;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            push            = 1'b1;
            outstanding_nxt = 1'b0;
            state_nxt       = issue_ok_after_push ? REQ : IDLE;
          end
        end
        FLUSH: begin
          if (imem.imem_rvalid) begin
            state_nxt       = REQ;
            outstanding_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_of_req   <= RESET_PC;
      outstanding <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      outstanding <= outstanding_nxt;
      if (state == REQ && imem.imem_gnt) pc_of_req <= pc;
    end
  end

  // pc only moves on gnt or redirect, so the address is stable while waiting.
  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = pc;

  assign push_data = '{pc: pc_of_req, instr: imem.imem_rdata};
  // A pop coinciding with a redirect is dropped: that entry is being flushed.
  assign pop       = fd_valid && fd_ready && !redirect;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (redirect),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fd_valid = !fifo_empty;
  assign fd_instr = fifo_empty ? NOP_INSTR : head.instr;
  assign fd_pc    = fifo_empty ? '0 : head.pc;

  // The issue rule leaves no room for a push into a full FIFO without a pop.
  assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed testbench for fetch_unit with a single-outstanding
// instruction-memory model (grant gated by gnt_en, response after lat cycles,
// data = 0xC0DE0000 | addr, optionally XORed with a per-request salt).
module tb_fetch_unit;
  import fetch_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             fd_valid;
  logic             fd_ready;
  logic [INS_W-1:0] fd_instr;
  logic [PC_W-1:0]  fd_pc;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;

  logic             gnt_en;
  int               lat;
  logic [31:0]      salt;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;

  fetch_if imem_bus();

  assign imem_bus.imem_gnt    = imem_bus.imem_req & gnt_en;
  assign imem_bus.imem_rvalid = mem_rvalid;
  assign imem_bus.imem_rdata  = mem_rdata;

  fetch_unit #(.DEPTH(2), .RESET_PC('0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_bus),
    .fd_valid    (fd_valid),
    .fd_ready    (fd_ready),
    .fd_instr    (fd_instr),
    .fd_pc       (fd_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory model state and observation queues.
  logic            pend = 1'b0;
  int              cnt = 0;
  logic [PC_W-1:0] paddr = '0;
  logic [31:0]     psalt = '0;

  logic [PC_W-1:0] issue_q[$];
  fetch_entry_t    pop_q[$];
  int              idle_bad = 0;
  logic            saw_forbidden = 1'b0;
  logic [31:0]     forbidden = 32'hFFFF_FFFF;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] data_of(input logic [PC_W-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] issue_at(input int i);
    if (i < issue_q.size()) return 32'(issue_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pop_pc_at(input int i);
    if (i < pop_q.size()) return 32'(pop_q[i].pc);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pop_instr_at(input int i);
    if (i < pop_q.size()) return pop_q[i].instr;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Stimulus changes at the falling edge, the memory model reacts 1 ns later,
  // the monitor samples 2 ns later; the DUT clocks on the rising edge.
  always @(negedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = data_of(paddr) ^ psalt;
        pend       = 1'b0;
      end
    end
    if (imem_bus.imem_req && imem_bus.imem_gnt) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = imem_bus.imem_addr;
      psalt = salt;
    end
    #1;
    if (imem_bus.imem_req && imem_bus.imem_gnt) issue_q.push_back(imem_bus.imem_addr);
    if (fd_valid && fd_ready && !redirect) pop_q.push_back('{pc: fd_pc, instr: fd_instr});
    if (!fd_valid && (fd_instr !== NOP_INSTR || fd_pc !== '0)) idle_bad++;
    if (fd_valid && fd_instr === forbidden) saw_forbidden = 1'b1;
  end

  task automatic restart(input int l, input logic rdy, input logic gen);
    reset    = 1'b0;
    redirect = 1'b0;
    gnt_en   = 1'b0;
    repeat (6) tick();
    issue_q.delete();
    pop_q.delete();
    forbidden     = 32'hFFFF_FFFF;
    saw_forbidden = 1'b0;
    salt          = '0;
    lat           = l;
    fd_ready      = rdy;
    gnt_en        = gen;
    reset         = 1'b1;
  endtask

  // Returns on the falling edge right after the cycle that granted addr.
  task automatic wait_issue(input logic [PC_W-1:0] addr, input int max, input string tag);
    logic found = 1'b0;
    for (int k = 0; k < max && !found; k++) begin
      tick();
      if (issue_q.size() > 0 && issue_q[issue_q.size()-1] == addr) found = 1'b1;
    end
    check({tag, "_issue_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    fd_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    gnt_en      = 1'b0;
    lat         = 1;
    salt        = '0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_req",   32'(imem_bus.imem_req),  32'd0);
    check("rst_addr",  32'(imem_bus.imem_addr), 32'd0);
    check("rst_valid", 32'(fd_valid),           32'd0);
    check("rst_instr", fd_instr,                32'h0000_0013);
    check("rst_pc",    32'(fd_pc),              32'd0);

    // 1: streaming fetch with a 1-cycle memory.
    restart(1, 1'b1, 1'b1);
    repeat (12) tick();
    check("t1_addr0",  issue_at(0), 32'h000);
    check("t1_addr1",  issue_at(1), 32'h004);
    check("t1_addr2",  issue_at(2), 32'h008);
    check("t1_pc0",    pop_pc_at(0), 32'h000);
    check("t1_pc1",    pop_pc_at(1), 32'h004);
    check("t1_pc2",    pop_pc_at(2), 32'h008);
    check("t1_ins0",   pop_instr_at(0), 32'hC0DE_0000);
    check("t1_ins1",   pop_instr_at(1), 32'hC0DE_0004);
    check("t1_ins2",   pop_instr_at(2), 32'hC0DE_0008);

    // 2: decode stalled, FIFO fills to DEPTH and fetch stops.
    restart(1, 1'b0, 1'b1);
    repeat (10) tick();
    check("t2_issued", 32'(issue_q.size()), 32'd2);
    check("t2_req",    32'(imem_bus.imem_req), 32'd0);
    check("t2_valid",  32'(fd_valid), 32'd1);
    check("t2_headpc", 32'(fd_pc), 32'h000);
    check("t2_headin", fd_instr, 32'hC0DE_0000);
    fd_ready = 1'b1;
    repeat (10) tick();
    check("t2_pc0",    pop_pc_at(0), 32'h000);
    check("t2_pc1",    pop_pc_at(1), 32'h004);
    check("t2_ins1",   pop_instr_at(1), 32'hC0DE_0004);
    check("t2_addr2",  issue_at(2), 32'h008);

    // 3: redirect one cycle after the grant of 0x10; its response is stale.
    restart(3, 1'b1, 1'b1);
    wait_issue(9'h010, 60, "t3");
    redirect      = 1'b1;
    redirect_pc   = 9'h040;
    forbidden     = data_of(9'h010);
    saw_forbidden = 1'b0;
    issue_q.delete();
    pop_q.delete();
    tick();
    redirect = 1'b0;
    repeat (15) tick();
    check("t3_next_addr", issue_at(0), 32'h040);
    check("t3_first_pc",  pop_pc_at(0), 32'h040);
    check("t3_first_ins", pop_instr_at(0), 32'hC0DE_0040);
    check("t3_no_stale",  32'(saw_forbidden), 32'd0);

    // 4: redirect while a request waits for its grant.
    restart(1, 1'b1, 1'b1);
    wait_issue(9'h004, 40, "t4");
    gnt_en = 1'b0;
    tick();
    check("t4_req_pre",  32'(imem_bus.imem_req),  32'd1);
    check("t4_addr_pre", 32'(imem_bus.imem_addr), 32'h008);
    redirect    = 1'b1;
    redirect_pc = 9'h023;
    tick();
    redirect = 1'b0;
    check("t4_req",      32'(imem_bus.imem_req),  32'd1);
    check("t4_addr",     32'(imem_bus.imem_addr), 32'h020);
    check("t4_empty",    32'(fd_valid), 32'd0);
    check("t4_npop",     32'(pop_q.size()), 32'd1);
    issue_q.delete();
    pop_q.delete();
    gnt_en = 1'b1;
    repeat (8) tick();
    check("t4_next_addr", issue_at(0), 32'h020);
    check("t4_first_pc",  pop_pc_at(0), 32'h020);
    check("t4_first_ins", pop_instr_at(0), 32'hC0DE_0020);

    // 5: PC wraps from 0x1FC to 0x000.
    restart(1, 1'b1, 1'b0);
    tick();
    redirect    = 1'b1;
    redirect_pc = 9'h1FC;
    tick();
    redirect = 1'b0;
    check("t5_addr", 32'(imem_bus.imem_addr), 32'h1FC);
    gnt_en = 1'b1;
    repeat (10) tick();
    check("t5_addr0", issue_at(0), 32'h1FC);
    check("t5_addr1", issue_at(1), 32'h000);
    check("t5_pc0",   pop_pc_at(0), 32'h1FC);
    check("t5_pc1",   pop_pc_at(1), 32'h000);
    check("t5_ins1",  pop_instr_at(1), 32'hC0DE_0000);

    // 6: reset during WAIT; the abandoned response arrives after release.
    restart(3, 1'b1, 1'b1);
    salt          = 32'h5A5A_0000;
    forbidden     = data_of(9'h000) ^ 32'h5A5A_0000;
    saw_forbidden = 1'b0;
    wait_issue(9'h000, 20, "t6");
    reset  = 1'b0;
    gnt_en = 1'b0;
    salt   = '0;
    tick();
    check("t6_rst_req", 32'(imem_bus.imem_req), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    check("t6_valid_a", 32'(fd_valid), 32'd0);
    check("t6_req",     32'(imem_bus.imem_req), 32'd1);
    check("t6_addr",    32'(imem_bus.imem_addr), 32'h000);
    tick();
    check("t6_valid_b", 32'(fd_valid), 32'd0);
    issue_q.delete();
    pop_q.delete();
    gnt_en = 1'b1;
    repeat (12) tick();
    check("t6_addr0",    issue_at(0), 32'h000);
    check("t6_pc0",      pop_pc_at(0), 32'h000);
    check("t6_ins0",     pop_instr_at(0), 32'hC0DE_0000);
    check("t6_no_stale", 32'(saw_forbidden), 32'd0);

    // fd_instr/fd_pc read NOP/0 in every cycle fd_valid was low.
    check("idle_outputs", 32'(idle_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
